fetch_sequencer: RTL and testbench

Sequences the combinational 32-word instruction memory: owns the word-indexed program counter, drives the memory address each cycle, and captures fetched words with their PC into a small FIFO feeding decode through a valid/ready handshake. It sits between the instruction memory and the decode stage. It handles redirect (branch/jump) with flush, stall from decode back-pressure, halt, and PC wrap-around at the end of memory.

---
 rtl/fetch_sequencer.sv | 150 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the word-indexed PC, drives the combinational
// instruction memory address and buffers fetched {pc, word} pairs in a small
// FIFO that feeds decode over a valid/ready handshake. A redirect flushes the
// FIFO and reloads the PC. A halt stops fetching but lets the FIFO drain.
module fetch_sequencer #(
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int RESET_PC = 0
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        wrapped,
  output logic [1:0]  state_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_W-1:0] RST_PC   = ADDR_W'(RESET_PC);
  localparam logic [ADDR_W-1:0] PC_ONE   = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] PC_LAST  = {ADDR_W{1'b1}};
  localparam logic [PW-1:0]     PTR_ONE  = PW'(1);
  localparam logic [PW:0]       CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]       CNT_FULL = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_nxt_s;
  logic [ADDR_W-1:0] pc_r;
  logic [PW-1:0]     rd_ptr_r;
  logic [PW-1:0]     wr_ptr_r;
  logic [PW:0]       count_r;
  logic              wrapped_r;
  logic [ADDR_W-1:0] fifo_pc_r   [DEPTH];
  logic [31:0]       fifo_data_r [DEPTH];

  logic push_s;
  logic pop_s;
  logic unused_redirect_bits_s;

  // Only the low ADDR_W bits of a redirect target select a word.
  assign unused_redirect_bits_s = ^redirect_pc[31:ADDR_W];

  assign inst_valid = (count_r != {(PW + 1){1'b0}});
  assign pop_s      = inst_valid && inst_ready;
  assign push_s     = (state_r == FETCH) && !redirect_valid && !halt &&
                      ((count_r < CNT_FULL) || pop_s);

  assign imem_addr  = {{(32 - ADDR_W){1'b0}}, pc_r};
  assign inst_pc    = inst_valid ? {{(32 - ADDR_W){1'b0}}, fifo_pc_r[rd_ptr_r]} : 32'd0;
  assign inst_data  = inst_valid ? fifo_data_r[rd_ptr_r] : 32'd0;
  assign wrapped    = wrapped_r;
  assign state_o    = state_r;

  // Next-state logic: redirect always lands in FETCH, halt parks in HALTED.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        state_nxt_s = FETCH;
      end
      FETCH: begin
        if (redirect_valid) begin
          state_nxt_s = FETCH;
        end else if (halt) begin
          state_nxt_s = HALTED;
        end else begin
          state_nxt_s = FETCH;
        end
      end
      HALTED: begin
        if (redirect_valid || !halt) begin
          state_nxt_s = FETCH;
        end else begin
          state_nxt_s = HALTED;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // PC, FIFO pointers/occupancy and wrap pulse; redirect overrides everything.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_r      <= RST_PC;
      rd_ptr_r  <= {PW{1'b0}};
      wr_ptr_r  <= {PW{1'b0}};
      count_r   <= {(PW + 1){1'b0}};
      wrapped_r <= 1'b0;
    end else if (redirect_valid) begin
      pc_r      <= redirect_pc[ADDR_W-1:0];
      rd_ptr_r  <= {PW{1'b0}};
      wr_ptr_r  <= {PW{1'b0}};
      count_r   <= {(PW + 1){1'b0}};
      wrapped_r <= 1'b0;
    end else begin
      wrapped_r <= push_s && (pc_r == PC_LAST);
      if (push_s) begin
        pc_r     <= pc_r + PC_ONE;
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // FIFO storage: capture the fetched word together with the PC it came from.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc_r[i]   <= {ADDR_W{1'b0}};
        fifo_data_r[i] <= 32'd0;
      end
    end else if (push_s) begin
      fifo_pc_r[wr_ptr_r]   <= pc_r;
      fifo_data_r[wr_ptr_r] <= imem_data;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: a hand-computed vector table from reset, an
// asynchronous mid-operation reset, then randomized traffic checked against a
// queue-based reference model of the fetch rules.
module tb_fetch_sequencer;

  localparam int DEPTH = 2;
  localparam int MEMW  = 32;

  logic        clk;
  logic        reset_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        wrapped;
  logic [1:0]  state_o;

  logic [31:0] mem [MEMW];

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.ADDR_W(5), .DEPTH(DEPTH), .RESET_PC(0)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .halt           (halt),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .wrapped        (wrapped),
    .state_o        (state_o)
  );

  // Combinational instruction memory.
  assign imem_data = mem[imem_addr[4:0]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        ready;
    logic        hlt;
    logic        redir;
    logic [31:0] rpc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] eaddr;
    logic [1:0]  est;
    logic        ew;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic h, input logic rd,
                              input logic [31:0] rp, input logic v,
                              input logic [31:0] p, input logic [31:0] a,
                              input logic [1:0] s, input logic w);
    vec_t t;
    t.ready = r; t.hlt = h; t.redir = rd; t.rpc = rp;
    t.ev = v; t.epc = p; t.eaddr = a; t.est = s; t.ew = w;
    return t;
  endfunction

  // Reference model state.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] data;
  } ent_t;

  ent_t q[$];
  int   m_pc;
  bit   m_started;
  bit   m_running;
  bit   m_wrap;

  // One clock edge of the fetch rules, using the inputs in force at the edge.
  task automatic model_step();
    bit   popped;
    ent_t e;
    popped = (q.size() > 0) && inst_ready;
    m_wrap = 1'b0;
    if (redirect_valid) begin
      q.delete();
      m_pc      = int'(redirect_pc % 32'd32);
      m_started = 1'b1;
      m_running = 1'b1;
    end else begin
      if (popped) void'(q.pop_front());
      if (!m_started) begin
        m_started = 1'b1;
        m_running = 1'b1;
      end else if (m_running) begin
        if (halt) begin
          m_running = 1'b0;
        end else if (q.size() < DEPTH) begin
          e.pc   = m_pc;
          e.data = mem[m_pc];
          q.push_back(e);
          m_wrap = (m_pc == MEMW - 1);
          m_pc   = (m_pc + 1) % MEMW;
        end
      end else if (!halt) begin
        m_running = 1'b1;
      end
    end
  endtask

  function automatic logic [1:0] model_state();
    if (!m_started) return 2'd0;
    return m_running ? 2'd1 : 2'd2;
  endfunction

  vec_t tv [21];

  initial begin
    for (int k = 0; k < MEMW; k++) mem[k] = k + 100;
    reset_n        = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halt           = 1'b0;
    inst_ready     = 1'b0;

    //            rdy  hlt  rdr  rpc           valid pc     addr   st    wrap
    tv[0]  = mk(1'b0,1'b0,1'b0,32'd0,        1'b0,32'd0, 32'd0, 2'd1,1'b0);
    tv[1]  = mk(1'b0,1'b0,1'b0,32'd0,        1'b1,32'd0, 32'd1, 2'd1,1'b0);
    tv[2]  = mk(1'b0,1'b0,1'b0,32'd0,        1'b1,32'd0, 32'd2, 2'd1,1'b0);
    tv[3]  = mk(1'b0,1'b0,1'b0,32'd0,        1'b1,32'd0, 32'd2, 2'd1,1'b0);
    tv[4]  = mk(1'b0,1'b0,1'b0,32'd0,        1'b1,32'd0, 32'd2, 2'd1,1'b0);
    tv[5]  = mk(1'b1,1'b0,1'b0,32'd0,        1'b1,32'd1, 32'd3, 2'd1,1'b0);
    tv[6]  = mk(1'b1,1'b0,1'b0,32'd0,        1'b1,32'd2, 32'd4, 2'd1,1'b0);
    tv[7]  = mk(1'b1,1'b1,1'b0,32'd0,        1'b1,32'd3, 32'd4, 2'd2,1'b0);
    tv[8]  = mk(1'b1,1'b1,1'b0,32'd0,        1'b0,32'd0, 32'd4, 2'd2,1'b0);
    tv[9]  = mk(1'b1,1'b1,1'b1,32'hFFFFFFE7, 1'b0,32'd0, 32'd7, 2'd1,1'b0);
    tv[10] = mk(1'b1,1'b0,1'b0,32'd0,        1'b1,32'd7, 32'd8, 2'd1,1'b0);
    tv[11] = mk(1'b1,1'b0,1'b0,32'd0,        1'b1,32'd8, 32'd9, 2'd1,1'b0);
    tv[12] = mk(1'b0,1'b0,1'b1,32'd20,       1'b0,32'd0, 32'd20,2'd1,1'b0);
    tv[13] = mk(1'b1,1'b0,1'b0,32'd0,        1'b1,32'd20,32'd21,2'd1,1'b0);
    tv[14] = mk(1'b1,1'b0,1'b1,32'd30,       1'b0,32'd0, 32'd30,2'd1,1'b0);
    tv[15] = mk(1'b1,1'b0,1'b0,32'd0,        1'b1,32'd30,32'd31,2'd1,1'b0);
    tv[16] = mk(1'b1,1'b0,1'b0,32'd0,        1'b1,32'd31,32'd0, 2'd1,1'b1);
    tv[17] = mk(1'b1,1'b0,1'b0,32'd0,        1'b1,32'd0, 32'd1, 2'd1,1'b0);
    tv[18] = mk(1'b1,1'b1,1'b0,32'd0,        1'b0,32'd0, 32'd1, 2'd2,1'b0);
    tv[19] = mk(1'b0,1'b0,1'b0,32'd0,        1'b0,32'd0, 32'd1, 2'd1,1'b0);
    tv[20] = mk(1'b0,1'b0,1'b0,32'd0,        1'b1,32'd1, 32'd2, 2'd1,1'b0);

    // Reset state.
    #2;
    chk("rst_valid", {31'd0, inst_valid}, 32'd0);
    chk("rst_state", {30'd0, state_o}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    chk("rst_wrap", {31'd0, wrapped}, 32'd0);
    #10 reset_n = 1'b1;

    // Hand-computed vector table.
    for (int i = 0; i < 21; i++) begin
      inst_ready     = tv[i].ready;
      halt           = tv[i].hlt;
      redirect_valid = tv[i].redir;
      redirect_pc    = tv[i].rpc;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_valid", i), {31'd0, inst_valid}, {31'd0, tv[i].ev});
      chk($sformatf("v%0d_addr", i), imem_addr, tv[i].eaddr);
      chk($sformatf("v%0d_state", i), {30'd0, state_o}, {30'd0, tv[i].est});
      chk($sformatf("v%0d_wrap", i), {31'd0, wrapped}, {31'd0, tv[i].ew});
      if (tv[i].ev) begin
        chk($sformatf("v%0d_pc", i), inst_pc, tv[i].epc);
        chk($sformatf("v%0d_data", i), inst_data, tv[i].epc + 32'd100);
      end
    end

    // Fill the FIFO, then pull reset between edges.
    inst_ready     = 1'b0;
    halt           = 1'b0;
    redirect_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("pre_reset_pc", inst_pc, 32'd1);
    chk("pre_reset_addr", imem_addr, 32'd3);
    #2 reset_n = 1'b0;
    #1;
    chk("async_valid", {31'd0, inst_valid}, 32'd0);
    chk("async_state", {30'd0, state_o}, 32'd0);
    chk("async_addr", imem_addr, 32'd0);
    chk("async_wrap", {31'd0, wrapped}, 32'd0);

    // Randomized traffic against the reference model.
    for (int k = 0; k < MEMW; k++) mem[k] = $urandom;
    q.delete();
    m_pc      = 0;
    m_started = 1'b0;
    m_running = 1'b0;
    m_wrap    = 1'b0;
    #3 reset_n = 1'b1;
    for (int c = 0; c < 600; c++) begin
      inst_ready     = ($urandom_range(0, 9) < 6);
      halt           = ($urandom_range(0, 9) < 2);
      redirect_valid = ($urandom_range(0, 11) == 0);
      redirect_pc    = $urandom;
      @(posedge clk);
      model_step();
      #1;
      chk("rnd_valid", {31'd0, inst_valid}, {31'd0, q.size() != 0});
      chk("rnd_addr", imem_addr, m_pc);
      chk("rnd_state", {30'd0, state_o}, {30'd0, model_state()});
      chk("rnd_wrap", {31'd0, wrapped}, {31'd0, m_wrap});
      if (q.size() != 0) begin
        chk("rnd_pc", inst_pc, q[0].pc);
        chk("rnd_data", inst_data, q[0].data);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
